mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/rr_arbiter2.sv | 34 +++
 rtl/mem_port_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the two-master memory port arbiter.
package mem_arb_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef logic owner_t;

    localparam owner_t OWNER_CPU = 1'b0;
    localparam owner_t OWNER_DMA = 1'b1;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick; the last-grant pointer moves only when a grant is taken.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output owner_t     grant_c,
    output logic       valid_c
);

    owner_t last_q;

    // On a tie the master that did not win last time is chosen.
    always_comb begin
        valid_c = |req;
        grant_c = owner_t'(~last_q);
        case (req)
            2'b01:   grant_c = OWNER_CPU;
            2'b10:   grant_c = OWNER_DMA;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= OWNER_DMA;
        end else if (advance) begin
            last_q <= grant_c;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates CPU and DMA masters onto one memory port: IDLE -> ISSUE -> WAIT -> RESP.
// Optional busy watchdog compiled in with `define ARB_TIMEOUT_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned READ_LAT    = 1,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic              i_Req0,
    input  logic              i_Req1,
    input  logic              i_We0,
    input  logic              i_We1,
    input  logic [ADDR_W-1:0] i_Addr0,
    input  logic [ADDR_W-1:0] i_Addr1,
    input  logic [DATA_W-1:0] i_WData0,
    input  logic [DATA_W-1:0] i_WData1,
    output logic              o_Ack0,
    output logic              o_Ack1,
    output logic [DATA_W-1:0] o_RData,
    output logic              o_Err,
    output logic              o_WEnable,
    output logic              o_REnable,
    output logic [ADDR_W-1:0] o_WAddr,
    output logic [ADDR_W-1:0] o_RAddr,
    output logic [DATA_W-1:0] o_WData,
    input  logic [DATA_W-1:0] i_RData,
    input  logic              i_Err,
    input  logic              i_MemBusy
);

    localparam int unsigned CNT_W = 4;

    if (READ_LAT < 1 || READ_LAT > 15 || TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("mem_port_arbiter: READ_LAT must be 1..15 and TIMEOUT_CYC at least 1");
    end

    arb_state_t       state_q, state_d;
    owner_t           owner_q;
    logic             we_q;
    logic [CNT_W-1:0] cnt_q;

    owner_t   grant_c;
    logic     grant_valid_c;
    logic     grant_fire;
    logic     timeout_fire;
    owner_t   owner_next;
    mem_req_t sel;
    logic     issue_next;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned BUSY_W = $clog2(TIMEOUT_CYC + 1);
    logic [BUSY_W-1:0] busy_cnt_q;
`endif

    rr_arbiter2 u_rr (
        .clk     (i_Clk),
        .rst     (i_Rst),
        .req     ({i_Req1, i_Req0}),
        .advance (grant_fire),
        .grant_c (grant_c),
        .valid_c (grant_valid_c)
    );

    // Payload of whichever master the arbiter currently favours.
    always_comb begin
        sel = '{we: i_We0, addr: i_Addr0, wdata: i_WData0};
        if (grant_c == OWNER_DMA) begin
            sel = '{we: i_We1, addr: i_Addr1, wdata: i_WData1};
        end
    end

    // Next-state logic.
    always_comb begin
        state_d      = state_q;
        grant_fire   = 1'b0;
        timeout_fire = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (grant_valid_c && !i_MemBusy) begin
                    state_d    = ISSUE;
                    grant_fire = 1'b1;
                end
`ifdef ARB_TIMEOUT_EN
                else if (grant_valid_c && busy_cnt_q == BUSY_W'(TIMEOUT_CYC - 1)) begin
                    state_d      = RESP;
                    grant_fire   = 1'b1;
                    timeout_fire = 1'b1;
                end
`endif
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign owner_next = grant_fire ? grant_c : owner_q;
    assign issue_next = (state_d == ISSUE);

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Transaction context and the WAIT down-counter.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            owner_q <= OWNER_CPU;
            we_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            if (grant_fire) begin
                owner_q <= grant_c;
                we_q    <= sel.we;
            end
            if (state_q == ISSUE) begin
                cnt_q <= CNT_W'(READ_LAT - 1);
            end else if (state_q == WAIT && cnt_q != '0) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end else begin
                cnt_q <= '0;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Consecutive cycles an IDLE request has been blocked by a busy memory.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            busy_cnt_q <= '0;
        end else if (state_q == IDLE && grant_valid_c && i_MemBusy && !timeout_fire) begin
            busy_cnt_q <= busy_cnt_q + BUSY_W'(1);
        end else begin
            busy_cnt_q <= '0;
        end
    end
`endif

    // Outputs are registered so they line up with the state they belong to.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            o_Ack0    <= 1'b0;
            o_Ack1    <= 1'b0;
            o_RData   <= '0;
            o_Err     <= 1'b0;
            o_WEnable <= 1'b0;
            o_REnable <= 1'b0;
            o_WAddr   <= '0;
            o_RAddr   <= '0;
            o_WData   <= '0;
        end else begin
            o_WEnable <= issue_next && sel.we;
            o_REnable <= issue_next && !sel.we;
            o_WAddr   <= (issue_next && sel.we)  ? sel.addr  : '0;
            o_RAddr   <= (issue_next && !sel.we) ? sel.addr  : '0;
            o_WData   <= (issue_next && sel.we)  ? sel.wdata : '0;
            o_Ack0    <= (state_d == RESP) && (owner_next == OWNER_CPU);
            o_Ack1    <= (state_d == RESP) && (owner_next == OWNER_DMA);
            o_Err     <= (state_d == RESP) && (timeout_fire || i_Err);
            o_RData   <= (state_q == WAIT && state_d == RESP && !we_q) ? i_RData : '0;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, corner sequences, and a
// randomized run checked against a transaction-level schedule model.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int unsigned L  = 1;
    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, we0, we1, busy, ierr;
    logic [31:0] addr0, addr1, wdata0, wdata1, rdata;
    logic        ack0, ack1, err, wen, ren;
    logic [31:0] ordata, waddr, raddr, owdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.READ_LAT(L), .TIMEOUT_CYC(TO)) dut (
        .i_Clk(clk), .i_Rst(rst),
        .i_Req0(req0), .i_Req1(req1), .i_We0(we0), .i_We1(we1),
        .i_Addr0(addr0), .i_Addr1(addr1), .i_WData0(wdata0), .i_WData1(wdata1),
        .o_Ack0(ack0), .o_Ack1(ack1), .o_RData(ordata), .o_Err(err),
        .o_WEnable(wen), .o_REnable(ren), .o_WAddr(waddr), .o_RAddr(raddr), .o_WData(owdata),
        .i_RData(rdata), .i_Err(ierr), .i_MemBusy(busy)
    );

    typedef struct packed {
        logic        ack0, ack1, wen, ren, err;
        logic [31:0] waddr, raddr, wdata, rdata;
    } out_t;

    typedef struct packed {
        logic        req0, req1, we, busy, err;
        logic [31:0] addr, wdata, rdata;
    } in_t;

    typedef struct {
        in_t  vi;
        out_t vo;
    } vec_t;

    int passes = 0;
    int total  = 0;
    int cyc    = 0;

    function automatic out_t ex(logic a0, logic a1, logic we_s, logic re_s,
                                logic [31:0] a, logic [31:0] wd, logic [31:0] rd, logic e);
        out_t o;
        o.ack0  = a0;
        o.ack1  = a1;
        o.wen   = we_s;
        o.ren   = re_s;
        o.err   = e;
        o.waddr = we_s ? a : 32'h0;
        o.raddr = re_s ? a : 32'h0;
        o.wdata = we_s ? wd : 32'h0;
        o.rdata = rd;
        return o;
    endfunction

    function automatic in_t mk(logic r0, logic r1, logic we_i, logic [31:0] a, logic [31:0] wd,
                               logic b, logic [31:0] rd, logic e);
        in_t v;
        v.req0 = r0; v.req1 = r1; v.we = we_i; v.addr = a; v.wdata = wd;
        v.busy = b; v.rdata = rd; v.err = e;
        return v;
    endfunction

    function automatic out_t actual();
        out_t o;
        o.ack0 = ack0; o.ack1 = ack1; o.wen = wen; o.ren = ren; o.err = err;
        o.waddr = waddr; o.raddr = raddr; o.wdata = owdata; o.rdata = ordata;
        return o;
    endfunction

    task automatic check(input string name, input out_t exp_o);
        out_t act;
        act = actual();
        total++;
        if (act === exp_o) passes++;
        else $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp_o);
    endtask

    task automatic check_int(input string name, input int act, input int exp_v);
        total++;
        if (act == exp_v) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive(input in_t v);
        req0 = v.req0; req1 = v.req1; we0 = v.we; we1 = v.we;
        addr0 = v.addr; addr1 = v.addr; wdata0 = v.wdata; wdata1 = v.wdata;
        busy = v.busy; rdata = v.rdata; ierr = v.err;
    endtask

    task automatic do_reset();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    vec_t tbl[22];
    out_t z;

    initial begin
        int acks[$];
        int ack_cyc[$];
        int seen;
        int at;
        int strobes;
        int t0;

        z = '0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
        rst = 1'b1;
        step();
        step();

        // Write with busy first, then a read, then an error read and a clean read.
        for (int i = 0; i < 5; i++) tbl[i] = '{mk(1,0,1,32'h0,32'hAA55AA55,1,0,0), z};
        tbl[5]  = '{mk(1,0,1,32'h0,32'hAA55AA55,0,0,0), z};
        tbl[6]  = '{mk(1,0,1,32'h0,32'hAA55AA55,0,0,0), ex(0,0,1,0,32'h0,32'hAA55AA55,0,0)};
        tbl[7]  = '{mk(1,0,1,32'h0,32'hAA55AA55,0,32'hDEADBEEF,0), z};
        tbl[8]  = '{mk(0,1,0,32'h4,0,0,0,0), ex(1,0,0,0,0,0,0,0)};
        tbl[9]  = '{mk(0,1,0,32'h4,0,0,0,0), z};
        tbl[10] = '{mk(0,1,0,32'h4,0,0,0,0), ex(0,0,0,1,32'h4,0,0,0)};
        tbl[11] = '{mk(0,1,0,32'h4,0,0,32'h12345678,0), z};
        tbl[12] = '{mk(1,0,0,32'h8,0,0,0,0), ex(0,1,0,0,0,0,32'h12345678,0)};
        tbl[13] = '{mk(1,0,0,32'h8,0,0,0,0), z};
        tbl[14] = '{mk(1,0,0,32'h8,0,0,0,0), ex(0,0,0,1,32'h8,0,0,0)};
        tbl[15] = '{mk(1,0,0,32'h8,0,0,32'hCAFEF00D,1), z};
        tbl[16] = '{mk(0,1,0,32'hC,0,0,0,0), ex(1,0,0,0,0,0,32'hCAFEF00D,1)};
        tbl[17] = '{mk(0,1,0,32'hC,0,0,0,0), z};
        tbl[18] = '{mk(0,1,0,32'hC,0,0,0,0), ex(0,0,0,1,32'hC,0,0,0)};
        tbl[19] = '{mk(0,1,0,32'hC,0,0,32'h11111111,0), z};
        tbl[20] = '{mk(0,0,0,0,0,0,0,0), ex(0,1,0,0,0,0,32'h11111111,0)};
        tbl[21] = '{mk(0,0,0,0,0,0,0,0), z};

        rst = 1'b0;
        for (int i = 0; i < 22; i++) begin
            check($sformatf("vec%0d", i), tbl[i].vo);
            drive(tbl[i].vi);
            step();
        end

        // Both masters held: grants alternate starting with master 0 after reset.
        do_reset();
        drive(mk(1, 1, 0, 32'h100, 0, 0, 0, 0));
        for (int k = 0; k < 60 && acks.size() < 4; k++) begin
            step();
            if (ack0) begin acks.push_back(0); ack_cyc.push_back(cyc); end
            if (ack1) begin acks.push_back(1); ack_cyc.push_back(cyc); end
        end
        check_int("alt_count", acks.size(), 4);
        for (int k = 0; k < 4 && k < acks.size(); k++) begin
            check_int($sformatf("alt_owner%0d", k), acks[k], k % 2);
        end
        if (ack_cyc.size() >= 2) check_int("alt_gap", ack_cyc[1] - ack_cyc[0], int'(L) + 3);

        // Reset during WAIT abandons the transaction.
        do_reset();
        drive(mk(1, 0, 0, 32'h40, 0, 0, 0, 0));
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            step();
            if (ren) seen = 1;
        end
        check_int("rst_issue_seen", seen, 1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
        check("rst_mid_wait", z);
        step();
        check("rst_after1", z);
        step();
        check("rst_after2", z);

        // Memory held busy with a pending request.
        do_reset();
        drive(mk(1, 0, 1, 32'h80, 32'h5, 1, 0, 0));
        at = -1;
        strobes = 0;
        t0 = cyc;
        for (int k = 0; k < 20; k++) begin
            step();
            if (wen || ren) strobes++;
            if (ack0 && at < 0) begin
                at = cyc - t0;
                check("busy_ack", ex(1, 0, 0, 0, 0, 0, 0, 1));
            end
        end
`ifdef ARB_TIMEOUT_EN
        check_int("busy_ack_cycle", at, int'(TO));
`else
        check_int("busy_no_ack", at, -1);
`endif
        check_int("busy_no_strobe", strobes, 0);

        // Randomized traffic against a schedule model.
        do_reset();
        begin
            logic        m_req[2];
            logic        m_we[2];
            logic [31:0] m_addr[2];
            logic [31:0] m_wd[2];
            int   free_at, strobe_c, samp_c, ack_c, last, brun, w, t_own;
            logic t_we, exp_err, b, e;
            logic [31:0] t_addr, t_wd, exp_rd, rd;
            out_t eo;

            cyc = 0; free_at = 0; strobe_c = -1; samp_c = -1; ack_c = -1;
            last = 1; brun = 0; t_own = 0; t_we = 0; t_addr = 0; t_wd = 0;
            exp_rd = 0; exp_err = 0;
            for (int m = 0; m < 2; m++) begin
                m_req[m] = 0; m_we[m] = 0; m_addr[m] = 0; m_wd[m] = 0;
            end
            for (int n = 0; n < 1500; n++) begin
                eo = '0;
                if (cyc == strobe_c) eo = ex(0, 0, t_we, !t_we, t_addr, t_wd, 0, 0);
                if (cyc == ack_c) begin
                    eo.ack0 = (t_own == 0);
                    eo.ack1 = (t_own == 1);
                    eo.rdata = exp_rd;
                    eo.err = exp_err;
                end
                check("rand", eo);
                if (cyc == ack_c) m_req[t_own] = 0;
                for (int m = 0; m < 2; m++) begin
                    if (!m_req[m] && $urandom_range(0, 1) == 1) begin
                        m_req[m]  = 1;
                        m_we[m]   = 1'($urandom_range(0, 1));
                        m_addr[m] = $urandom;
                        m_wd[m]   = $urandom;
                    end
                end
                b  = ($urandom_range(0, 9) < 3);
                rd = $urandom;
                e  = ($urandom_range(0, 7) == 0);
                if (cyc == samp_c) begin
                    exp_rd  = t_we ? 32'h0 : rd;
                    exp_err = e;
                end
                if (cyc >= free_at && (m_req[0] || m_req[1])) begin
                    w = (m_req[0] && m_req[1]) ? 1 - last : (m_req[1] ? 1 : 0);
                    if (!b) begin
                        t_own = w; t_we = m_we[w]; t_addr = m_addr[w]; t_wd = m_wd[w];
                        strobe_c = cyc + 1;
                        samp_c   = cyc + 1 + int'(L);
                        ack_c    = cyc + 2 + int'(L);
                        free_at  = cyc + 3 + int'(L);
                        last = w;
                        brun = 0;
                    end else begin
`ifdef ARB_TIMEOUT_EN
                        brun++;
                        if (brun == int'(TO)) begin
                            t_own = w;
                            strobe_c = -1;
                            samp_c = -1;
                            ack_c = cyc + 1;
                            free_at = cyc + 2;
                            exp_rd = 0;
                            exp_err = 1;
                            last = w;
                            brun = 0;
                        end
`endif
                    end
                end else begin
                    brun = 0;
                end
                req0 = m_req[0]; we0 = m_we[0]; addr0 = m_addr[0]; wdata0 = m_wd[0];
                req1 = m_req[1]; we1 = m_we[1]; addr1 = m_addr[1]; wdata1 = m_wd[1];
                busy = b; rdata = rd; ierr = e;
                step();
            end
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
